// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable, output-valid flag and a
// sticky coverage mask of every code decoded since reset or clear.

module decoder_3to8_lane #(
   parameter int unsigned CODE = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] s,
   input  logic       en,
   input  logic       clr,
   output logic       o_q,
   output logic       seen_d,
   output logic       seen_q
);

   logic hit;
   logic o_d;

   always_comb begin
      hit    = en && (s == 3'(CODE));
      o_d    = hit;
      // clear wins over a hit in the same cycle
      seen_d = clr ? 1'b0 : (seen_q | hit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q    <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         o_q    <= o_d;
         seen_q <= seen_d;
      end
   end

endmodule

module decoder_3to8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] s,
   input  logic       en,
   input  logic       clr,
   output logic [7:0] o,
   output logic       valid,
   output logic [7:0] seen,
   output logic       all_seen
);

   localparam int unsigned NUM_LANES = 8;

   logic [NUM_LANES-1:0] o_q;
   logic [NUM_LANES-1:0] seen_q;
   logic [NUM_LANES-1:0] seen_d;
   logic                 valid_q;
   logic                 valid_d;
   logic                 all_seen_q;
   logic                 all_seen_d;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      decoder_3to8_lane #(.CODE(k)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .s      (s),
         .en     (en),
         .clr    (clr),
         .o_q    (o_q[k]),
         .seen_d (seen_d[k]),
         .seen_q (seen_q[k])
      );
   end

   // all_seen tracks the next mask so it moves in lockstep with seen
   always_comb begin
      valid_d    = en;
      all_seen_d = &seen_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         all_seen_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         all_seen_q <= all_seen_d;
      end
   end

   assign o        = o_q;
   assign valid    = valid_q;
   assign seen     = seen_q;
   assign all_seen = all_seen_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: stimulus pushes expected registered
// outputs, a monitor pops and compares one cycle later.

module tb_decoder_3to8;

   logic       clk;
   logic       rst_n;
   logic [2:0] s;
   logic       en;
   logic       clr;
   logic [7:0] o;
   logic       valid;
   logic [7:0] seen;
   logic       all_seen;

   typedef struct {
      logic [7:0] o;
      logic       v;
      logic [7:0] seen;
      logic       all;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_id  = 0;
   logic [7:0] m_seen;

   decoder_3to8 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (s),
      .en       (en),
      .clr      (clr),
      .o        (o),
      .valid    (valid),
      .seen     (seen),
      .all_seen (all_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp);
   endtask

   // Monitor: one registered result per clock, checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("o", e.id, o, e.o);
         chk("valid", e.id, {7'd0, valid}, {7'd0, e.v});
         chk("seen", e.id, seen, e.seen);
         chk("all_seen", e.id, {7'd0, all_seen}, {7'd0, e.all});
         chk("onehot", e.id, {7'd0, ($countones(o) <= 1)}, 8'd1);
      end
   end

   // Directed step with hand-computed expectations.
   task automatic step(input logic [2:0] si, input logic ei, input logic ci,
                       input logic [7:0] eo, input logic ev, input logic [7:0] es, input logic ea);
      exp_t e;
      @(negedge clk);
      s = si; en = ei; clr = ci;
      step_id++;
      e.o = eo; e.v = ev; e.seen = es; e.all = ea; e.id = step_id;
      exp_q.push_back(e);
      m_seen = es;
   endtask

   // Model-driven step used for the random phase.
   task automatic rstep(input logic [2:0] si, input logic ei, input logic ci);
      logic [7:0] eo;
      eo = ei ? (8'd1 << si) : 8'd0;
      if (ci) m_seen = 8'd0;
      else    m_seen = m_seen | eo;
      step(si, ei, ci, eo, ei, m_seen, m_seen == 8'hFF);
   endtask

   initial begin
      rst_n = 1'b0; s = 3'd5; en = 1'b1; clr = 1'b0; m_seen = 8'd0;

      // Reset held with clocks running and en=1
      for (int i = 0; i < 3; i++) step(3'd5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 8'h20, 1'b0);

      // Full sweep
      step(3'd0, 1'b1, 1'b0, 8'h01, 1'b1, 8'h21, 1'b0);
      step(3'd1, 1'b1, 1'b0, 8'h02, 1'b1, 8'h23, 1'b0);
      step(3'd2, 1'b1, 1'b0, 8'h04, 1'b1, 8'h27, 1'b0);
      step(3'd3, 1'b1, 1'b0, 8'h08, 1'b1, 8'h2F, 1'b0);
      step(3'd4, 1'b1, 1'b0, 8'h10, 1'b1, 8'h3F, 1'b0);
      step(3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 8'h3F, 1'b0);
      step(3'd6, 1'b1, 1'b0, 8'h40, 1'b1, 8'h7F, 1'b0);
      step(3'd7, 1'b1, 1'b0, 8'h80, 1'b1, 8'hFF, 1'b1);
      step(3'd7, 1'b1, 1'b0, 8'h80, 1'b1, 8'hFF, 1'b1);

      // Enable gating
      for (int i = 0; i < 4; i++) step(3'd3, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1);
      step(3'd3, 1'b1, 1'b0, 8'h08, 1'b1, 8'hFF, 1'b1);

      // Coverage clear beats a same-cycle decode
      step(3'd2, 1'b1, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0);
      step(3'd2, 1'b1, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0);
      step(3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

      // Rebuild to 7F, then async reset between edges
      step(3'd0, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01, 1'b0);
      step(3'd1, 1'b1, 1'b0, 8'h02, 1'b1, 8'h03, 1'b0);
      step(3'd2, 1'b1, 1'b0, 8'h04, 1'b1, 8'h07, 1'b0);
      step(3'd3, 1'b1, 1'b0, 8'h08, 1'b1, 8'h0F, 1'b0);
      step(3'd4, 1'b1, 1'b0, 8'h10, 1'b1, 8'h1F, 1'b0);
      step(3'd5, 1'b1, 1'b0, 8'h20, 1'b1, 8'h3F, 1'b0);
      step(3'd6, 1'b1, 1'b0, 8'h40, 1'b1, 8'h7F, 1'b0);
      @(posedge clk);
      #3;
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_o", 0, o, 8'h00);
      chk("async_valid", 0, {7'd0, valid}, 8'h00);
      chk("async_seen", 0, seen, 8'h00);
      chk("async_all", 0, {7'd0, all_seen}, 8'h00);
      rst_n = 1'b1;
      m_seen = 8'd0;

      // Random run: one-hot invariant and monotonic coverage
      for (int i = 0; i < 1000; i++)
         rstep(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));

      // Drain with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
